demux4_deser: RTL
=================

Name: demux4_deser

Overview:
- Downstream consumer of the 1:4 demux.
- Samples the demux's four outputs (a, b, c, d) under the same sel that steers the demux.
- Accumulates serial bits per channel into WIDTH-bit words and stores one completed word per channel in a holding register.
- Delivers words one at a time on a valid/ready output, with round-robin arbitration across channels.

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- bit_vld  input  1  demux outputs hold a valid bit this cycle
- sel  input  2  demux select: 00=a, 01=b, 10=c, 11=d
- a  input  1  demux channel 0 output
- b  input  1  demux channel 1 output
- c  input  1  demux channel 2 output
- d  input  1  demux channel 3 output
- out_valid  output  1  out_data/out_ch valid
- out_ready  input  1  consumer accepts the word
- out_data  output  WIDTH  assembled word
- out_ch  output  2  source channel of out_data
- ovf  output  4  sticky per-channel overflow flags
- ovf_clr  input  1  synchronous clear of all ovf bits

Behaviour:
- Reset: rst_n low asynchronously clears:
  - all shift registers, bit counters, holding registers and hold_full flags;
  - out_valid=0, out_data=0, out_ch=0, ovf=0;
  - round-robin pointer (channel 0 highest priority).
- Reset mid-word discards partial bits. Clock edges are ignored while rst_n is low.
- Bit capture: when bit_vld=1 at a clk edge:
  - bit = line selected by sel; the other three lines are ignored.
  - LSB-first shift into sr[sel]: sr <= {bit, sr[WIDTH-1:1]}.
  - cnt[sel] increments. Other channels are untouched.
  - bit_vld=0: no capture-side state change.
- Word completion: the edge capturing bit index WIDTH-1 on a channel does all of:
  - writes the completed word (including that bit) into hold[sel];
  - sets hold_full[sel];
  - clears cnt[sel] to 0.
- Overflow:
  - If hold_full[sel] is already set and that holding register is not drained on the same edge, the new word is dropped, ovf[sel] is set, and cnt still clears.
  - Drain and completion on the same channel in the same edge: accepted, no overflow.
- Output register FSM:
  - IDLE (out_valid=0): if any hold_full is set, load the round-robin winner (search from pointer upward, wrapping 3->0). Set out_data, out_ch and out_valid=1; clear that hold_full; pointer <= winner+1 mod 4. Go to VALID.
  - VALID: out_data/out_ch stable while out_ready=0.
  - VALID with out_ready=1: if another hold_full is set, load the next winner on the same edge and stay VALID (back-to-back, one word per cycle). Otherwise go to IDLE with out_valid=0.
- Latency: word-completing edge N; out_valid is high after edge N+1 at the earliest.
- ovf bits stay set until ovf_clr=1 at an edge. A new overflow on the same edge as ovf_clr wins (bit stays 1).
- Capacity per channel: 1 word in holding plus 1 word in output register, shared across channels.

Optional Feature:
- Macro DEMUX4_DESER_MSB_FIRST_EN.
- Defined: shift is MSB-first, sr <= {sr[WIDTH-2:0], bit]; the first received bit lands in out_data[WIDTH-1].
- Undefined: LSB-first as above.
- Everything else is identical in both builds.

Test Plan:
1. WIDTH=8, out_ready=1, sel=00, bit_vld=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 -> out_valid high one edge after the 8th bit, out_data=0xA5, out_ch=0; out_valid low on the next cycle.
2. Interleave sel=01 and sel=10 each cycle: ch1 sends 0x3C, ch2 sends 0xC3 (LSB-first, ch1 first per pair) -> ch1/0x3C delivered, then ch2/0xC3; ovf=0.
3. out_ready=0; complete 0x11 on ch0, 0x22 on ch1, 0x33 on ch2, 0x44 on ch3 -> out_valid=1 holding ch0/0x11 stable. Then out_ready=1 -> 0x22, 0x33, 0x44 on consecutive cycles (ch1, ch2, ch3), then out_valid=0.
4. out_ready=0; ch3 completes 0x55, 0x66, 0x77 -> output holds 0x55, hold[3]=0x66, 0x77 dropped, ovf=4'b1000. Then out_ready=1 -> 0x55 then 0x66. Pulse ovf_clr -> ovf=0.
5. ch0: 4 bits of 1, rst_n low 2 cycles -> outputs zero immediately. After release, ch0 sends 0x0F -> out_data=0x0F (no leftover bits).
6. Build with DEMUX4_DESER_MSB_FIRST_EN; ch2 sends bits 0,1,1,1,1,0,0,0 -> out_data=0x78, out_ch=2. The same stream without the macro gives 0x1E.

Source files
------------

// File: rtl/demux4_deser.sv
// Four-channel serial-to-parallel deserializer behind a 1:4 demux, with round-robin word delivery.
// Optional build macro DEMUX4_DESER_MSB_FIRST_EN switches bit assembly from LSB-first to MSB-first.
module demux4_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld,
  input  logic [1:0]       sel,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic [3:0]       ovf,
  input  logic             ovf_clr
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_VALID} state_t;

  logic [WIDTH-1:0] r_sr   [4];
  logic [CW-1:0]    r_cnt  [4];
  logic [WIDTH-1:0] r_hold [4];
  logic [3:0]       r_hold_full;
  logic [3:0]       r_ovf;
  logic [1:0]       r_ptr;
  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_ch;

  logic             w_bit;
  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic             w_any;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_found;
  logic             w_load;
  logic [3:0]       w_drain;
  logic [3:0]       w_ovf_set;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic bi);
`ifdef DEMUX4_DESER_MSB_FIRST_EN
    return {sr[WIDTH-2:0], bi};
`else
    return {bi, sr[WIDTH-1:1]};
`endif
  endfunction

  always_comb begin
    case (sel)
      2'd0:    w_bit = a;
      2'd1:    w_bit = b;
      2'd2:    w_bit = c;
      default: w_bit = d;
    endcase
  end

  assign w_word = shift_in(r_sr[sel], w_bit);
  assign w_done = bit_vld && (r_cnt[sel] == LAST);

  // Round-robin search starting at the pointer, wrapping 3 -> 0.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && r_hold_full[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_any   = |r_hold_full;
  assign w_load  = w_any && (!r_out_valid || out_ready);
  assign w_drain = w_load ? (4'b0001 << w_win) : 4'b0000;

  always_comb begin
    w_ovf_set = 4'b0000;
    if (w_done && r_hold_full[sel] && !w_drain[sel])
      w_ovf_set[sel] = 1'b1;
  end

  // Capture side: shift registers, bit counters, holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_sr[k]   <= '0;
        r_cnt[k]  <= '0;
        r_hold[k] <= '0;
      end
      r_hold_full <= '0;
      r_ovf       <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bit_vld && (sel == 2'(k))) begin
          r_sr[k] <= w_word;
          if (r_cnt[k] == LAST) begin
            r_cnt[k] <= '0;
            if (!w_ovf_set[k]) begin
              r_hold[k]      <= w_word;
              r_hold_full[k] <= 1'b1;
            end
          end else begin
            r_cnt[k] <= r_cnt[k] + 1'b1;
            if (w_drain[k]) r_hold_full[k] <= 1'b0;
          end
        end else if (w_drain[k]) begin
          r_hold_full[k] <= 1'b0;
        end
      end
      r_ovf <= (ovf_clr ? 4'b0000 : r_ovf) | w_ovf_set;
    end
  end

  // Output register FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= 2'd0;
      r_ptr       <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_out_data  <= r_hold[w_win];
            r_out_ch    <= w_win;
            r_out_valid <= 1'b1;
            r_ptr       <= w_win + 2'd1;
            r_state     <= S_VALID;
          end
        end
        S_VALID: begin
          if (out_ready) begin
            if (w_any) begin
              r_out_data  <= r_hold[w_win];
              r_out_ch    <= w_win;
              r_out_valid <= 1'b1;
              r_ptr       <= w_win + 2'd1;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign ovf       = r_ovf;

endmodule
